vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.
//  Produces the hCount/vCount/bright/hSync/vSync stream consumed by the rendering controller and the VGA pins.
//  Adds a per-frame tick and a frame counter for sprite animation and game-tick sequencing.
//  Sits between the board clock and the rendering controller / VGA connector.
// PARAMETERS
//  CLK_DIV   4    clk cycles per pixel; 100 MHz / 4 = 25 MHz pixel rate; legal values 2..8
//  H_TOTAL   800  pixels per line; hCount range 0..799
//  V_TOTAL   525  lines per frame; vCount range 0..524
//  H_SYNC    96   hSync low while hCount < H_SYNC
//  V_SYNC    2    vSync low while vCount < V_SYNC
//  H_VIS_LO  144  first visible column
//  H_VIS_HI  783  last visible column
//  V_VIS_LO  35   first visible line
//  V_VIS_HI  514  last visible line
//  SYNC_DLY  1    pixel ticks of delay on hSync/vSync/bright, to match ROM read latency; legal values 0..4
// PORTS
//  clk          in   1   100 MHz system clock; the only clock in the block
//  reset        in   1   asynchronous, active-high reset
//  pix_en       out  1   one-clk strobe per pixel; high when divider = CLK_DIV-1
//  hCount       out  10  current column, undelayed; used to address the sprite ROMs
//  vCount       out  10  current line, undelayed
//  bright       out  1   visible-area flag, delayed by SYNC_DLY pixels
//  hSync        out  1   active-low horizontal sync, delayed by SYNC_DLY pixels
//  vSync        out  1   active-low vertical sync, delayed by SYNC_DLY pixels
//  frame_tick   out  1   one-clk pulse at frame wrap
//  frame_count  out  8   frames since reset; wraps 255 -> 0
// BEHAVIOUR
//  Reset (async assert, release sampled on clk):
//   - divider = 0; pix_en = 0; hCount = 0; vCount = 0.
//   - bright = 0, hSync = 0, vSync = 0, frame_tick = 0, frame_count = 0.
//   - Every SYNC_DLY pipeline stage resets to the values for count (0,0): bright 0, hSync 0, vSync 0.
//  Divider:
//   - Counts 0..CLK_DIV-1 and wraps.
//   - pix_en is registered and is high for exactly one clk in every CLK_DIV clks.
//   - First pix_en occurs CLK_DIV clks after reset release.
//  Counters:
//   - Counters are registered and change only on clks where pix_en = 1.
//   - hCount increments each pixel. At H_TOTAL-1 it wraps to 0 and vCount increments.
//   - At vCount = V_TOTAL-1 with hCount = H_TOTAL-1, both wrap to 0.
//   - Counters never leave their legal ranges.
//  Decode from the undelayed counts:
//   - hs_raw = (hCount >= H_SYNC).
//   - vs_raw = (vCount >= V_SYNC).
//   - br_raw = H_VIS_LO <= hCount <= H_VIS_HI, and V_VIS_LO <= vCount <= V_VIS_HI.
//  Delay pipeline:
//   - hs_raw/vs_raw/br_raw pass through a SYNC_DLY-deep shift register that advances only on pix_en.
//   - With SYNC_DLY = 0 the outputs are the combinational decode of the registered counts.
//   - With SYNC_DLY = N, the outputs during pixel k equal the decode of pixel k-N, wrapping across line and frame.
//  Frame:
//   - frame_tick = 1 on the same clk in which the counters wrap from (799,524) to (0,0).
//   - frame_count increments on that same clk.
//   - The wrap 255 -> 0 produces no extra pulse.
//  Reset mid-frame: all state returns to the reset values immediately; no partial frame_tick is issued.
//  No handshake: the block free-runs and consumers sample on pix_en.
// TESTING
//  1. Release reset, run 12 clks -> pix_en high on clks 4, 8, 12 only; hCount steps 0 -> 1 -> 2 -> 3; vCount stays 0.
//  2. Drive to hCount = 799, vCount = 10, then one pix_en -> hCount = 0, vCount = 11; frame_tick stays 0.
//  3. SYNC_DLY = 0, line 40 -> hSync low for hCount 0..95 and high at 96; bright high at 144 and 783, low at 143 and 784.
//  4. SYNC_DLY = 0 -> bright low on lines 34 and 515, high on lines 35 and 514; vSync low on lines 0..1 only.
//  5. Run 1,680,000 clks from reset -> exactly one frame_tick, frame_count = 1; after 256 frames frame_count = 0.
//  6. SYNC_DLY = 2 -> bright rises at hCount = 146; assert reset at (300,200) -> all outputs at reset values in the same clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing from the board clock, with delayed
// sync/bright outputs plus a per-frame tick and frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_SYNC   = 96,
  parameter int V_SYNC   = 2,
  parameter int H_VIS_LO = 144,
  parameter int H_VIS_HI = 783,
  parameter int V_VIS_LO = 35,
  parameter int V_VIS_HI = 514,
  parameter int SYNC_DLY = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_END = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS    = 10'(H_SYNC);
  localparam logic [9:0] VS    = 10'(V_SYNC);
  localparam logic [9:0] HV_LO = 10'(H_VIS_LO);
  localparam logic [9:0] HV_HI = 10'(H_VIS_HI);
  localparam logic [9:0] VV_LO = 10'(V_VIS_LO);
  localparam logic [9:0] VV_HI = 10'(V_VIS_HI);

  logic [DW-1:0] div;
  logic          tick;
  logic          h_end;
  logic          v_end;
  logic          hs_raw;
  logic          vs_raw;
  logic          br_raw;

  assign tick  = (div == DIV_END);
  assign h_end = (hCount == H_END);
  assign v_end = (vCount == V_END);

  // Counters and strobes all move on the same edge that ends a pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      pix_en      <= 1'b0;
      hCount      <= '0;
      vCount      <= '0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      div        <= tick ? '0 : div + 1'b1;
      pix_en     <= tick;
      frame_tick <= tick & h_end & v_end;
      if (tick) begin
        if (h_end) begin
          hCount <= '0;
          if (v_end) begin
            vCount      <= '0;
            frame_count <= frame_count + 8'd1;
          end else begin
            vCount <= vCount + 10'd1;
          end
        end else begin
          hCount <= hCount + 10'd1;
        end
      end
    end
  end

  assign hs_raw = (hCount >= HS);
  assign vs_raw = (vCount >= VS);
  assign br_raw = (hCount >= HV_LO) && (hCount <= HV_HI) &&
                  (vCount >= VV_LO) && (vCount <= VV_HI);

  generate
    if (SYNC_DLY == 0) begin : g_nodly
      assign bright = br_raw;
      assign hSync  = hs_raw;
      assign vSync  = vs_raw;
    end else begin : g_dly
      // Stage i holds the decode of the pixel i+1 ticks back.
      logic [2:0] pipe [SYNC_DLY];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < SYNC_DLY; i++) pipe[i] <= 3'b000;
        end else if (tick) begin
          pipe[0] <= {br_raw, hs_raw, vs_raw};
          for (int i = 1; i < SYNC_DLY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign bright = pipe[SYNC_DLY-1][2];
      assign hSync  = pipe[SYNC_DLY-1][1];
      assign vSync  = pipe[SYNC_DLY-1][0];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: two reduced-geometry instances (16x8 raster),
// one undelayed at CLK_DIV 4, one delayed by 2 pixels at CLK_DIV 2.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en_a, bright_a, hSync_a, vSync_a, frame_tick_a;
  logic [9:0] hCount_a, vCount_a;
  logic [7:0] frame_count_a;
  logic       pix_en_b, bright_b, hSync_b, vSync_b, frame_tick_b;
  logic [9:0] hCount_b, vCount_b;
  logic [7:0] frame_count_b;

  int errors = 0;
  int checks = 0;
  int e = 0;
  int ticks_a = 0;
  int ticks_b = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(4), .H_TOTAL(16), .V_TOTAL(8), .H_SYNC(3), .V_SYNC(2),
    .H_VIS_LO(4), .H_VIS_HI(13), .V_VIS_LO(3), .V_VIS_HI(6),
    .SYNC_DLY(0)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_en(pix_en_a),
    .hCount(hCount_a), .vCount(vCount_a), .bright(bright_a),
    .hSync(hSync_a), .vSync(vSync_a), .frame_tick(frame_tick_a),
    .frame_count(frame_count_a)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(16), .V_TOTAL(8), .H_SYNC(3), .V_SYNC(2),
    .H_VIS_LO(4), .H_VIS_HI(13), .V_VIS_LO(3), .V_VIS_HI(6),
    .SYNC_DLY(2)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_en_b),
    .hCount(hCount_b), .vCount(vCount_b), .bright(bright_b),
    .hSync(hSync_b), .vSync(vSync_b), .frame_tick(frame_tick_b),
    .frame_count(frame_count_b)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_tick_a) ticks_a++;
      if (frame_tick_b) ticks_b++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    e += n;
    @(negedge clk);
  endtask

  task automatic go(input int t);
    adv(t - e);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_pe_a"}, int'(pix_en_a), 0);
    chk({tag, "_h_a"}, int'(hCount_a), 0);
    chk({tag, "_v_a"}, int'(vCount_a), 0);
    chk({tag, "_br_a"}, int'(bright_a), 0);
    chk({tag, "_hs_a"}, int'(hSync_a), 0);
    chk({tag, "_vs_a"}, int'(vSync_a), 0);
    chk({tag, "_ft_a"}, int'(frame_tick_a), 0);
    chk({tag, "_fc_a"}, int'(frame_count_a), 0);
    chk({tag, "_pe_b"}, int'(pix_en_b), 0);
    chk({tag, "_h_b"}, int'(hCount_b), 0);
    chk({tag, "_v_b"}, int'(vCount_b), 0);
    chk({tag, "_br_b"}, int'(bright_b), 0);
    chk({tag, "_hs_b"}, int'(hSync_b), 0);
    chk({tag, "_vs_b"}, int'(vSync_b), 0);
    chk({tag, "_ft_b"}, int'(frame_tick_b), 0);
    chk({tag, "_fc_b"}, int'(frame_count_b), 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("rst");
    reset = 1'b0;
    e = 0;

    for (int i = 1; i <= 12; i++) begin
      adv(1);
      chk("s1_pe_a", int'(pix_en_a), (i % 4 == 0) ? 1 : 0);
      chk("s1_h_a", int'(hCount_a), i / 4);
      chk("s1_v_a", int'(vCount_a), 0);
    end

    go(255);
    chk("s2_h_a", int'(hCount_a), 15);
    chk("s2_v_a", int'(vCount_a), 3);
    chk("s2_h_b", int'(hCount_b), 15);
    chk("s2_v_b", int'(vCount_b), 7);
    chk("s2_ft_b", int'(frame_tick_b), 0);
    chk("s2_fc_b", int'(frame_count_b), 0);
    go(256);
    chk("wrap_h_a", int'(hCount_a), 0);
    chk("wrap_v_a", int'(vCount_a), 4);
    chk("wrap_ft_a", int'(frame_tick_a), 0);
    chk("wrap_hs_a", int'(hSync_a), 0);
    chk("wrap_vs_a", int'(vSync_a), 1);
    chk("wrap_br_a", int'(bright_a), 0);
    chk("fr_ft_b", int'(frame_tick_b), 1);
    chk("fr_fc_b", int'(frame_count_b), 1);
    chk("fr_h_b", int'(hCount_b), 0);
    chk("fr_v_b", int'(vCount_b), 0);
    chk("fr_hs_b", int'(hSync_b), 1);
    chk("fr_vs_b", int'(vSync_b), 1);
    chk("fr_br_b", int'(bright_b), 0);
    go(257);
    chk("fr1_ft_b", int'(frame_tick_b), 0);
    chk("fr1_fc_b", int'(frame_count_b), 1);

    for (int h = 1; h <= 15; h++) begin
      go(257 + 4 * h);
      chk("s3_h_a", int'(hCount_a), h);
      chk("s3_v_a", int'(vCount_a), 4);
      chk("s3_hs_a", int'(hSync_a), (h >= 3) ? 1 : 0);
      chk("s3_br_a", int'(bright_a), (h >= 4 && h <= 13) ? 1 : 0);
    end

    go(512);
    chk("fr_ft_a", int'(frame_tick_a), 1);
    chk("fr_fc_a", int'(frame_count_a), 1);
    chk("fr_h_a", int'(hCount_a), 0);
    chk("fr_v_a", int'(vCount_a), 0);
    chk("fr2_ft_b", int'(frame_tick_b), 1);
    chk("fr2_fc_b", int'(frame_count_b), 2);

    for (int v = 0; v <= 7; v++) begin
      go(4 * (133 + 16 * v) + 1);
      chk("s4_h_a", int'(hCount_a), 5);
      chk("s4_v_a", int'(vCount_a), v);
      chk("s4_vs_a", int'(vSync_a), (v >= 2) ? 1 : 0);
      chk("s4_br_a", int'(bright_a), (v >= 3 && v <= 6) ? 1 : 0);
    end

    go(1089);
    chk("d_v_b", int'(vCount_b), 2);
    chk("d_vs0_b", int'(vSync_b), 0);
    go(1093);
    chk("d_vs1_b", int'(vSync_b), 1);
    go(1129);
    chk("d_h4_b", int'(hCount_b), 4);
    chk("d_hs0_b", int'(hSync_b), 0);
    go(1131);
    chk("d_hs1_b", int'(hSync_b), 1);
    chk("d_br0_b", int'(bright_b), 0);
    go(1133);
    chk("d_h6_b", int'(hCount_b), 6);
    chk("d_br1_b", int'(bright_b), 1);
    go(1151);
    chk("d_brhi_b", int'(bright_b), 1);
    go(1153);
    chk("d_brln_b", int'(bright_b), 0);
    chk("d_v4_b", int'(vCount_b), 4);

    #1 reset = 1'b1;
    #1 chk_rst("midrst");
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_rst("hold");
    reset = 1'b0;
    e = 0;
    mon_en = 1'b1;

    adv(4);
    chk("re_pe_a", int'(pix_en_a), 1);
    chk("re_h_a", int'(hCount_a), 1);
    chk("re_pe_b", int'(pix_en_b), 1);
    chk("re_h_b", int'(hCount_b), 2);
    chk("re_br_b", int'(bright_b), 0);
    chk("re_hs_b", int'(hSync_b), 0);

    go(65535);
    chk("w_fc_b", int'(frame_count_b), 255);
    chk("w_ft_b", int'(frame_tick_b), 0);
    go(65536);
    chk("w0_ft_b", int'(frame_tick_b), 1);
    chk("w0_fc_b", int'(frame_count_b), 0);
    chk("w0_h_b", int'(hCount_b), 0);
    chk("w0_v_b", int'(vCount_b), 0);
    chk("w0_ft_a", int'(frame_tick_a), 1);
    chk("w0_fc_a", int'(frame_count_a), 128);
    go(65537);
    chk("w1_ft_b", int'(frame_tick_b), 0);
    chk("w1_fc_b", int'(frame_count_b), 0);
    chk("ticks_a", ticks_a, 128);
    chk("ticks_b", ticks_b, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
